// File: rtl/alu_divider_pkg.sv
// Shared ALU definitions: divider state encoding and the divide-by-zero quotient.
package alu_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int ALU_WIDTH = 8;
   localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/alu_divider_add_sub.sv
// Combinational WIDTH-bit adder/subtractor; sub=1 computes a - b in two's complement.
module alu_divider_add_sub #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] y
);

   assign y = a + (b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/alu_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module alu_divider
   import alu_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_t       state;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   // R < D always, so the top bit of the (WIDTH+1)-bit remainder is never set
   // between steps; only the low WIDTH bits are kept.
   logic [WIDTH-1:0] r;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;

   assign shifted = {r, q[WIDTH-1]};

   alu_divider_add_sub #(
      .WIDTH(WIDTH + 1)
   ) u_trial_sub (
      .a  (shifted),
      .b  ({1'b0, d}),
      .sub(1'b1),
      .y  (diff)
   );

   // diff[WIDTH] is the sign: clear means the trial subtraction fits.
   always_comb begin
      q_next = {q[WIDTH-2:0], ~diff[WIDTH]};
      r_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         d           <= '0;
         q           <= '0;
         r           <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  d           <= divisor;
                  q           <= dividend;
                  r           <= '0;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  if (divisor == '0) begin
                     // Replicating the reduced constant keeps it all ones at any WIDTH.
                     quotient    <= {WIDTH{&DIV_ZERO_QUOTIENT}};
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               q   <= q_next;
               r   <= r_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  quotient  <= q_next;
                  remainder <= r_next;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_divider.sv
// Bench for alu_divider: directed cases, ignored start, mid-run reset and a random sweep
// checked against an arithmetic reference model.
module tb_alu_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad   = 0;
   logic [2*W:0] exp_q[$];

   alu_divider #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: {div_by_zero, quotient, remainder} from plain integer arithmetic.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      int qi, ri;
      if (b == 0) return {1'b1, {W{1'b1}}, a};
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
      return {1'b0, qi[W-1:0], ri[W-1:0]};
   endfunction

   // Runs one division and checks busy/done every cycle. inj >= 0 pulses a second
   // start (10/2) in the cycle after edge E(inj), which the divider must ignore.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
      logic [2*W:0] e;
      int lat;
      exp_q.push_back(model(a, b));
      lat = (b == 0) ? 0 : W;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      for (int k = 0; k <= lat; k++) begin
         @(posedge clk);
         #1;
         start = (k == inj);
         if (k == inj) begin
            dividend = 8'd10;
            divisor  = 8'd2;
         end
         check("busy_run", busy, 1);
         check("done_timing", done, k == lat);
      end
      e = exp_q.pop_front();
      check("quotient", quotient, e[2*W-1:W]);
      check("remainder", remainder, e[W-1:0]);
      check("div_by_zero", div_by_zero, e[2*W]);
      if (b != 0) begin
         check("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
         check("rem_lt_div", remainder < b, 1);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_end", busy, 0);
      check("done_end", done, 0);
      check("quotient_hold", quotient, e[2*W-1:W]);
      check("remainder_hold", remainder, e[W-1:0]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ra, rb;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      do_div(8'd100, 8'd7, -1);
      do_div(8'd255, 8'd1, -1);
      do_div(8'd5, 8'd9, -1);
      do_div(8'd255, 8'd255, -1);
      do_div(8'd42, 8'd0, -1);
      do_div(8'd0, 8'd13, -1);
      do_div(8'd200, 8'd3, 3);
      do_div(8'd9, 8'd4, -1);

      // Mid-run reset: outputs clear asynchronously and no done pulse follows.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_dbz", div_by_zero, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("abort_no_done", {busy, done}, 2'b00);
      end
      @(negedge clk);
      rst = 1'b0;
      do_div(8'd9, 8'd4, -1);

      for (int n = 0; n < 2000; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
         do_div(ra, rb, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
